// File: rtl/keypad_encoder.sv
// Keypad front end for the countdown timer: synchronises and debounces ten digit
// buttons and emits one active-low load strobe carrying the BCD digit per press.
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enn,
    input  logic [9:0] keys,
    output logic [3:0] data,
    output logic       loadn,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       cand_reg, cand_next;
    logic [3:0]       data_reg, data_next;
    logic             loadn_reg, loadn_next;
    logic [9:0]       sync1_reg, ks_reg;
    logic [9:0]       hit;
    logic [3:0]       enc;
    logic             any;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_reg <= '0;
            ks_reg    <= '0;
        end else begin
            sync1_reg <= keys;
            ks_reg    <= sync1_reg;
        end
    end

    // One-hot of the lowest pressed key: simultaneous presses resolve downward.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_hit
            if (gi == 0) begin : g_first
                assign hit[gi] = ks_reg[gi];
            end else begin : g_rest
                assign hit[gi] = ks_reg[gi] & ~(|ks_reg[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (hit[i]) begin
                enc = enc | 4'(i);
            end
        end
    end

    assign any = |ks_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cand_reg  <= 4'd0;
            data_reg  <= 4'd0;
            loadn_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            data_reg  <= data_next;
            loadn_reg <= loadn_next;
        end
    end

    // Outputs are computed for the state being entered, so loadn is low exactly
    // while the state register holds EMIT.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        data_next  = data_reg;
        loadn_next = 1'b1;
        case (state_reg)
            IDLE: begin
                if (any && !enn) begin
                    cand_next  = enc;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!any || enn) begin
                    state_next = IDLE;
                end else if (enc != cand_reg) begin
                    cand_next = enc;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = EMIT;
                    data_next  = cand_reg;
                    loadn_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            EMIT: begin
                state_next = WAIT_RELEASE;
                cnt_next   = '0;
            end
            WAIT_RELEASE: begin
                if (any) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data  = data_reg;
    assign loadn = loadn_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a run-length model of press/release acceptance checked
// every cycle, plus literal strobe timing/data expectations per scenario.
module tb_keypad_encoder;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       enn;
    logic [9:0] keys;
    logic [3:0] data;
    logic       loadn;
    logic       busy;

    keypad_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk  (clk),
        .clr  (clr),
        .enn  (enn),
        .keys (keys),
        .data (data),
        .loadn(loadn),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt   = 0;
    int strobes_seen = 0;
    int last_strobe_edge = -1;

    // Model: keys seen through two sample delays; a press is accepted after DC+1
    // consecutive enabled edges showing the same lowest key, a release after DC
    // consecutive quiet edges once the strobe cycle is over.
    logic [9:0] m_k1, m_k2;
    bit         m_valid = 0;
    bit         m_release = 0;
    bit         m_just_emitted = 0;
    int         m_run = 0;
    int         m_quiet = 0;
    logic [3:0] m_digit = 4'd0;
    logic [3:0] m_data = 4'd0;
    logic       m_loadn = 1'b1;
    logic       m_busy = 1'b0;

    function automatic logic [3:0] lowest_key(input logic [9:0] k);
        lowest_key = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (k[i]) lowest_key = 4'(i);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task model_step();
        logic [3:0] e;
        if (clr) begin
            m_valid = 1;
            m_k1 = '0;
            m_k2 = '0;
            m_release = 0;
            m_just_emitted = 0;
            m_run = 0;
            m_quiet = 0;
            m_data = 4'd0;
            m_loadn = 1'b1;
        end else begin
            m_loadn = 1'b1;
            if (m_just_emitted) begin
                m_just_emitted = 0;
                m_release = 1;
                m_quiet = 0;
            end else if (m_release) begin
                if (m_k2 != 0) m_quiet = 0;
                else m_quiet++;
                if (m_quiet == DC) begin
                    m_release = 0;
                    m_run = 0;
                end
            end else if (m_k2 != 0 && !enn) begin
                e = lowest_key(m_k2);
                if (m_run > 0 && e == m_digit) m_run++;
                else begin
                    m_run = 1;
                    m_digit = e;
                end
                if (m_run == DC + 1) begin
                    m_data = e;
                    m_loadn = 1'b0;
                    m_just_emitted = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_k2 = m_k1;
            m_k1 = keys;
        end
        m_busy = m_just_emitted || m_release || (m_run > 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            model_step();
            #1;
            if (m_valid) begin
                check("data", 32'(data), 32'(m_data));
                check("loadn", 32'(loadn), 32'(m_loadn));
                check("busy", 32'(busy), 32'(m_busy));
                if (loadn === 1'b0) begin
                    strobes_seen++;
                    last_strobe_edge = edge_cnt;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0;
        int e0;
        clr = 1'b1;
        enn = 1'b0;
        keys = '0;
        tick(2);
        check("rst_data", 32'(data), 0);
        check("rst_loadn", 32'(loadn), 1);
        check("rst_busy", 32'(busy), 0);
        clr = 1'b0;
        tick(20);
        check("idle_strobes", strobes_seen, 0);
        check("idle_busy", 32'(busy), 0);

        // Digit 5 held 30 cycles, then released
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0000100000;
        tick(30);
        check("d5_count", strobes_seen - s0, 1);
        check("d5_edge", last_strobe_edge, e0 + 6);
        check("d5_data", 32'(data), 5);
        keys = '0;
        tick(5);
        check("d5_busy_hold", 32'(busy), 1);
        tick(1);
        check("d5_busy_fall", 32'(busy), 0);
        tick(5);

        // Bounce on digit 7: 2 high, 1 low, then held
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0010000000;
        tick(2);
        keys = '0;
        tick(1);
        keys = 10'b0010000000;
        tick(20);
        check("bounce_count", strobes_seen - s0, 1);
        check("bounce_edge", last_strobe_edge, e0 + 9);
        check("bounce_data", 32'(data), 7);
        keys = '0;
        tick(10);

        // Keys 3 and 8 together
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0100001000;
        tick(15);
        check("multi_count", strobes_seen - s0, 1);
        check("multi_edge", last_strobe_edge, e0 + 6);
        check("multi_data", 32'(data), 3);
        keys = '0;
        tick(10);

        // Key 8 joins key 3 mid-debounce: no restart
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0000001000;
        tick(3);
        keys = 10'b0100001000;
        tick(15);
        check("join_count", strobes_seen - s0, 1);
        check("join_edge", last_strobe_edge, e0 + 6);
        check("join_data", 32'(data), 3);
        keys = '0;
        tick(10);

        // Entry blocked, then enabled while digit 2 still held
        s0 = strobes_seen; enn = 1'b1; keys = 10'b0000000100;
        tick(15);
        check("enn_block_count", strobes_seen - s0, 0);
        check("enn_block_busy", 32'(busy), 0);
        enn = 1'b0; e0 = edge_cnt + 1;
        tick(15);
        check("enn_fall_count", strobes_seen - s0, 1);
        check("enn_fall_edge", last_strobe_edge, e0 + 4);
        check("enn_fall_data", 32'(data), 2);
        keys = '0;
        tick(10);

        // enn rising mid-debounce aborts the press
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0000000100;
        tick(4);
        check("enn_rise_busy_pre", 32'(busy), 1);
        enn = 1'b1;
        tick(15);
        check("enn_rise_count", strobes_seen - s0, 0);
        check("enn_rise_busy", 32'(busy), 0);
        keys = '0;
        tick(5);
        enn = 1'b0;
        tick(5);

        // clr during DEBOUNCE, key stays held -> fresh press
        s0 = strobes_seen; e0 = edge_cnt + 1; keys = 10'b0000010000;
        tick(3);
        check("clr_db_busy_pre", 32'(busy), 1);
        clr = 1'b1;
        tick(1);
        check("clr_db_busy", 32'(busy), 0);
        check("clr_db_loadn", 32'(loadn), 1);
        check("clr_db_data", 32'(data), 0);
        clr = 1'b0;
        tick(12);
        check("clr_db_count", strobes_seen - s0, 1);
        check("clr_db_edge", last_strobe_edge, e0 + 10);
        check("clr_db_data4", 32'(data), 4);

        // clr during WAIT_RELEASE, key still held -> fresh press again
        check("clr_wr_busy_pre", 32'(busy), 1);
        clr = 1'b1; e0 = edge_cnt + 1;
        tick(1);
        check("clr_wr_busy", 32'(busy), 0);
        check("clr_wr_loadn", 32'(loadn), 1);
        check("clr_wr_data", 32'(data), 0);
        clr = 1'b0;
        tick(12);
        check("clr_wr_count", strobes_seen - s0, 2);
        check("clr_wr_edge", last_strobe_edge, e0 + 7);
        check("clr_wr_data4", 32'(data), 4);
        keys = '0;
        tick(10);
        check("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Sits on the write side of the countdown timer's digit-load interface. It drives the timer's `data` and `loadn` inputs.
- Takes ten raw active-high digit pushbuttons, synchronises and debounces them, and encodes the pressed key to BCD.
- Emits exactly one active-low `loadn` strobe per accepted press. The timer shifts that digit into its ones position.
- Entry can be blocked via `enn`, e.g. while the oven is cooking.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a press or a release; legal range 1..65535.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clr  input  1  synchronous active-high reset
- enn  input  1  active-low entry enable; 1 blocks new presses
- keys  input  10  raw pushbuttons, bit i = digit i, active-high, asynchronous to clk
- data  output  4  BCD digit to the timer, registered, holds last emitted digit
- loadn  output  1  active-low one-cycle load strobe to the timer
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (`clr`=1 at edge):
  - state=IDLE, sync regs=0, counter=0, cand=0.
  - data=4'd0, loadn=1, busy=0.
  - Reset has priority over everything and aborts any operation mid-press; no strobe is issued.
- Synchroniser: 2-flop stage on all 10 bits; ks = second stage. All decisions use ks only.
- Encoding: enc = index of the lowest set bit of ks (0..9); any = |ks. Multiple keys resolve to the lowest index.
- IDLE:
  - If any && !enn: cand<=enc, cnt<=0, go DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - !any or enn=1: go IDLE, no strobe.
  - any && enc!=cand: cand<=enc, cnt<=0, stay.
  - any && enc==cand && cnt==DEBOUNCE_CYCLES-1: go EMIT.
  - Otherwise cnt<=cnt+1.
- EMIT (exactly one cycle):
  - Registered outputs in this cycle: loadn=0, data=cand.
  - Next state WAIT_RELEASE, cnt<=0, unconditionally. `enn` and `keys` are ignored, because the press is committed.
- WAIT_RELEASE:
  - any: cnt<=0, stay.
  - !any && cnt==DEBOUNCE_CYCLES-1: go IDLE.
  - !any otherwise: cnt<=cnt+1.
  - A held key never re-triggers. A second key pressed while the first is still held is ignored.
- Outputs:
  - loadn is 1 in every state except EMIT.
  - data changes only on entry to EMIT and is stable at all other times.
  - busy = (state!=IDLE).
- Latency, with raw key first sampled high at edge 0 and held:
  - ks high after edge 1; DEBOUNCE entered at edge 2.
  - EMIT entered at edge DEBOUNCE_CYCLES+2; loadn low for the cycle between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
- Minimum press-to-press spacing: a new press is accepted only after release has been stable for DEBOUNCE_CYCLES cycles and IDLE has been re-entered.
- Glitches: any raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no strobe.
- Counter: unsigned CNT_W bits; it never exceeds DEBOUNCE_CYCLES-1, so no wrap.

Test Plan:
- Reset, then idle with keys=0 for 20 cycles -> data=0, loadn=1, busy=0 throughout.
- DEBOUNCE_CYCLES=4: keys=10'b0000100000 (digit 5) held from edge 0 for 30 cycles, then released -> loadn=0 only between edges 6 and 7, data=4'd5 from edge 6 onward, no further strobe while held. busy falls 4 stable-release cycles after ks clears.
- Bounce: digit 7 pulsed 2 cycles high, 1 low, 2 high, then held -> no strobe during the bounce; exactly one strobe with data=7 after 4 stable cycles.
- Simultaneous keys 3 and 8 held -> single strobe with data=3. Key 8 added mid-debounce while key 3 is held keeps cand=3 and gives no restart.
- `enn`=1 while digit 2 is held -> no strobe. `enn` falling while the key is still held -> strobe with data=2 DEBOUNCE_CYCLES+1 cycles later. `enn` rising mid-DEBOUNCE -> return to IDLE, no strobe.
- `clr` asserted during DEBOUNCE and again during WAIT_RELEASE -> next edge: state IDLE, loadn=1, data=0, busy=0. The key still held after reset release is treated as a fresh press.
